imem_loader: RTL and testbench

Program loader for the single-cycle MIPS instruction memory. Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions and writes them into the writable instruction memory (64 words, 6-bit word address). It holds the processor in reset while loading and releases it only after a verified load.

---
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes big-endian 32-bit words into the instruction memory, and holds the CPU until a verified load.
//
// state   | meaning
// S_IDLE  | waiting for start, CPU released
// S_LEN   | accepting the word-count byte
// S_DATA  | accepting data bytes into the shift register
// S_WRITE | one-cycle memory write of the assembled word
// S_CSUM  | accepting and comparing the checksum byte
// S_DONE  | one-cycle completion pulse, CPU released
// S_ERR   | failed load, CPU held until a new start
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_data_i,
   output logic          byte_ready_o,
   output logic          we_o,
   output logic [AW-1:0] waddr_o,
   output logic [31:0]   wdata_o,
   output logic          cpu_hold_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          error_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CSUM  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [8:0] DEPTH_B = 9'(DEPTH);
   localparam logic [AW:0] ONE    = (AW+1)'(1);

   state_t        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   word_idx_q, word_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [31:0]   sr_q, sr_d;
   logic [7:0]    csum_q, csum_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         sr_q       <= '0;
         csum_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         sr_q       <= sr_d;
         csum_q     <= csum_d;
      end
   end

   // Byte-consuming states only advance on byte_valid_i; ready is already implied by the state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      sr_d       = sr_q;
      csum_d     = csum_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start_i) begin
               state_d    = S_LEN;
               cnt_d      = '0;
               word_idx_d = '0;
               byte_idx_d = '0;
               sr_d       = '0;
               csum_d     = '0;
            end
         end
         S_LEN: begin
            if (byte_valid_i) begin
               if (byte_data_i == 8'd0 || {1'b0, byte_data_i} > DEPTH_B) begin
                  state_d = S_ERR;
               end else begin
                  cnt_d      = byte_data_i[AW:0];
                  csum_d     = byte_data_i;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  state_d    = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_valid_i) begin
               sr_d       = {sr_q[23:0], byte_data_i};
               csum_d     = csum_q ^ byte_data_i;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            word_idx_d = word_idx_q + ONE;
            state_d    = (word_idx_q == cnt_q - ONE) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (byte_valid_i) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign we_o         = (state_q == S_WRITE);
   assign waddr_o      = word_idx_q[AW-1:0];
   assign wdata_o      = sr_q;
   assign busy_o       = (state_q == S_LEN) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_CSUM);
   assign cpu_hold_o   = busy_o || (state_q == S_ERR);
   assign done_o       = (state_q == S_DONE);
   assign error_o      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a separate monitor pops and compares them whenever we_o is seen.
module tb_imem_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        we_o;
   logic [5:0]  waddr_o;
   logic [31:0] wdata_o;
   logic        cpu_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [37:0] exp_q[$];

   imem_loader #(.DEPTH(64), .AW(6)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .cpu_hold_o   (cpu_hold_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every write must match the head of the expected queue and never coincide with ready.
   initial begin
      logic [37:0] e;
      forever begin
         @(negedge clk_i);
         if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", waddr_o, wdata_o);
            end else begin
               e = exp_q.pop_front();
               check("write_addr_data", {26'd0, waddr_o, wdata_o}, {26'd0, e});
            end
            check("ready_low_in_write", {63'd0, byte_ready_o}, 64'd0);
         end
      end
   end

   task automatic start_pulse();
      @(negedge clk_i);
      start_i = 1'b1;
      cyc = 0;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      check("busy_after_start", {62'd0, busy_o, error_o}, 64'b10);
      check("hold_after_start", {63'd0, cpu_hold_o}, 64'd1);
   endtask

   task automatic send_bytes(input bq_t b, input bit rnd);
      int idx = 0;
      int t = 0;
      logic v;
      while (idx < b.size() && t < 3000) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_valid_i = v;
         byte_data_i  = b[idx];
         if (v && byte_ready_o) idx++;
         @(negedge clk_i);
         cyc++;
         t++;
      end
      byte_valid_i = 1'b0;
      if (idx < b.size()) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: sent %0d bytes, expected %0d", idx, b.size());
      end
   endtask

   task automatic wait_end(input bit exp_ok, input int exp_cyc);
      int t = 0;
      while (!done_o && !error_o && t < 100) begin
         @(negedge clk_i);
         cyc++;
         t++;
      end
      if (exp_ok) begin
         check("done_seen", {63'd0, done_o}, 64'd1);
         if (exp_cyc >= 0) check("done_latency", 64'(cyc), 64'(exp_cyc));
         check("hold_low_at_done", {63'd0, cpu_hold_o}, 64'd0);
         @(negedge clk_i);
         check("done_one_cycle", {62'd0, done_o, busy_o}, 64'd0);
      end else begin
         check("error_state", {61'd0, error_o, cpu_hold_o, done_o}, 64'b110);
         @(negedge clk_i);
         check("error_sticky", {62'd0, error_o, cpu_hold_o}, 64'b11);
      end
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic push_two_words();
      exp_q.push_back({6'd0, 32'h2002_0005});
      exp_q.push_back({6'd1, 32'h2003_000C});
   endtask

   initial begin
      bq_t good, bad, s;
      logic [7:0] cs;

      reset_i = 1'b1;
      start_i = 1'b0;
      byte_valid_i = 1'b0;
      byte_data_i = 8'h00;
      good = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h0A};
      bad  = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h0B};
      repeat (3) @(negedge clk_i);
      check("reset_ctrl", {57'd0, byte_ready_o, we_o, cpu_hold_o, busy_o, done_o, error_o, 1'b0}, 64'd0);
      check("reset_addr_data", {26'd0, waddr_o, wdata_o}, 64'd0);
      reset_i = 1'b0;
      @(negedge clk_i);

      // Two-word load at full throughput.
      push_two_words();
      start_pulse();
      send_bytes(good, 1'b0);
      wait_end(1'b1, 13);

      // Bad checksum, then recovery from ERR.
      push_two_words();
      start_pulse();
      send_bytes(bad, 1'b0);
      wait_end(1'b0, -1);
      push_two_words();
      start_pulse();
      send_bytes(good, 1'b0);
      wait_end(1'b1, 13);

      // Illegal lengths 0 and 65.
      s = '{8'h00};
      start_pulse();
      send_bytes(s, 1'b0);
      wait_end(1'b0, -1);
      s = '{8'h41};
      start_pulse();
      send_bytes(s, 1'b0);
      wait_end(1'b0, -1);

      // Full depth, word i = i.
      s = '{8'h40};
      cs = 8'h40;
      for (int i = 0; i < 64; i++) begin
         s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'(i));
         cs ^= 8'(i);
         exp_q.push_back({6'(i), 32'(i)});
      end
      s.push_back(cs);
      start_pulse();
      send_bytes(s, 1'b0);
      wait_end(1'b1, 5 * 64 + 3);

      // Backpressure on the two-word stream.
      for (int r = 0; r < 3; r++) begin
         push_two_words();
         start_pulse();
         send_bytes(good, 1'b1);
         wait_end(1'b1, -1);
      end

      // Reset between byte 2 and byte 3 of word 1.
      exp_q.push_back({6'd0, 32'h2002_0005});
      s = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03};
      start_pulse();
      send_bytes(s, 1'b0);
      check("midload_busy", {63'd0, busy_o}, 64'd1);
      #1;
      reset_i = 1'b1;
      #1;
      check("async_reset_ctrl", {57'd0, byte_ready_o, we_o, cpu_hold_o, busy_o, done_o, error_o, 1'b0}, 64'd0);
      check("async_reset_addr_data", {26'd0, waddr_o, wdata_o}, 64'd0);
      check("midload_write_seen", 64'(exp_q.size()), 64'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      push_two_words();
      start_pulse();
      send_bytes(good, 1'b0);
      wait_end(1'b1, 13);

      repeat (3) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
